// File: rtl/lfsr_seq_ctrl.sv
// Fetch/execute sequencer for the 11-bit LFSR instruction set.
// Owns the PC, fetches from a synchronous ROM and stretches st/ld/run into multi-cycle ops.
module lfsr_seq_ctrl #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               rom_en,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               mem_wr_in,
  input  logic               lfsr_lmem_in,
  input  logic               lfsr_run_in,
  input  logic               halt_in,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic               mem_done,
  output logic               lfsr_step,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_MEM,
    S_RUN,
    S_HALT
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PC_W-1:0]      pc_nxt;
  logic [PC_W-1:0]      pc_inc;
  logic [INSTR_W-1:0]   instr_nxt;
  logic [7:0]           cnt;
  logic [7:0]           cnt_nxt;

  // Natural PC_W-bit overflow gives the required modulo-2^PC_W wrap.
  assign pc_inc   = pc + PC_W'(1);
  assign rom_addr = pc;
  assign mem_done = mem_req & mem_ack;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: begin
        instr_nxt = rom_data;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (halt_in) begin
          state_nxt = S_HALT;
        end else if (mem_wr_in || lfsr_lmem_in) begin
          state_nxt = S_MEM;
        end else if (lfsr_run_in) begin
          cnt_nxt = instr[7:0];
          if (instr[7:0] == 8'd0) begin
            pc_nxt    = pc_inc;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_RUN;
          end
        end else begin
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt - 8'd1;
        // cnt is never 0 here; <= 1 keeps a corrupted count from spinning 256 steps.
        if (cnt <= 8'd1) begin
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each is a clean flop aligned with its state.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      cnt         <= '0;
      rom_en      <= 1'b0;
      instr_valid <= 1'b0;
      mem_req     <= 1'b0;
      lfsr_step   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      cnt         <= cnt_nxt;
      rom_en      <= (state_nxt == S_FETCH);
      instr_valid <= (state_nxt == S_EXEC);
      mem_req     <= (state_nxt == S_MEM);
      lfsr_step   <= (state_nxt == S_RUN);
      busy        <= (state_nxt inside {S_FETCH, S_LATCH, S_EXEC, S_MEM, S_RUN});
      done        <= (state_nxt == S_HALT);
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl: directed table, hand-written corner sequences,
// and random programs checked cycle by cycle against an instruction-level trace model.
module tb_lfsr_seq_ctrl;

  localparam logic [2:0] OP_ST = 3'd0, OP_LD = 3'd1, OP_IA = 3'd2, OP_AA = 3'd3;
  localparam logic [2:0] OP_CFG = 3'd4, OP_IL = 3'd5, OP_RUN = 3'd6, OP_HALT = 3'd7;

  logic        clk;
  logic        reset, start, start2;
  logic        rom_en, instr_valid, mem_req, mem_done, lfsr_step, busy, done;
  logic [7:0]  rom_addr, pc;
  logic [10:0] rom_data, instr;
  logic        mem_wr_in, lfsr_lmem_in, lfsr_run_in, halt_in, mem_ack;
  logic        rom_en2, instr_valid2, mem_req2, mem_done2, lfsr_step2, busy2, done2;
  logic [1:0]  rom_addr2, pc2;
  logic [10:0] rom_data2, instr2;

  lfsr_seq_ctrl #(.PC_W(8), .INSTR_W(11)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(instr), .instr_valid(instr_valid),
    .mem_wr_in(mem_wr_in), .lfsr_lmem_in(lfsr_lmem_in), .lfsr_run_in(lfsr_run_in), .halt_in(halt_in),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_done(mem_done), .lfsr_step(lfsr_step),
    .pc(pc), .busy(busy), .done(done)
  );

  lfsr_seq_ctrl #(.PC_W(2), .INSTR_W(11)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .instr(instr2), .instr_valid(instr_valid2),
    .mem_wr_in(1'b0), .lfsr_lmem_in(1'b0), .lfsr_run_in(1'b0), .halt_in(1'b0),
    .mem_req(mem_req2), .mem_ack(1'b0), .mem_done(mem_done2), .lfsr_step(lfsr_step2),
    .pc(pc2), .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rom_en;
    logic [7:0]  addr;
    logic        valid;
    logic        req;
    logic        mdone;
    logic        step;
    logic        busy;
    logic        done;
    logic [7:0]  pc;
    logic [10:0] instr;
  } obs_t;

  typedef struct {
    logic [10:0] ins;
    int          ack_wait;
    int          done_cyc;
    int          steps;
    int          reqs;
    int          mdone;
    int          valids;
    int          pc_end;
  } tcase_t;

  logic [10:0] rom [256];
  logic [10:0] rom2 [4];
  int          ack_q[$];
  obs_t        exp_q[$];
  int          req_n, cur_d, cyc;
  bit          rand_mode, force_both;
  int          tests, fails;

  function automatic logic [10:0] mk(input logic [2:0] op, input logic [7:0] immi);
    return {op, immi};
  endfunction

  function automatic obs_t obs_now();
    obs_t o;
    o.rom_en = rom_en;  o.addr = rom_addr;  o.valid = instr_valid;
    o.req    = mem_req; o.mdone = mem_done; o.step  = lfsr_step;
    o.busy   = busy;    o.done  = done;     o.pc    = pc;
    o.instr  = instr;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: synchronous ROMs, decoder and memory responder respond to the new DUT state.
  task automatic tick();
    logic       e1, e2;
    logic [7:0] a1;
    logic [1:0] a2;
    e1 = rom_en;  a1 = rom_addr;
    e2 = rom_en2; a2 = rom_addr2;
    @(posedge clk);
    #1;
    cyc++;
    if (e1) rom_data = rom[a1];
    if (e2) rom_data2 = rom2[a2];
    mem_wr_in    = (instr[10:8] == OP_ST) || (force_both && instr[10:8] == OP_HALT);
    lfsr_lmem_in = (instr[10:8] == OP_LD);
    lfsr_run_in  = (instr[10:8] == OP_RUN);
    halt_in      = (instr[10:8] == OP_HALT);
    if (mem_req) begin
      req_n++;
      if (req_n == 1) cur_d = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
      mem_ack = (req_n == cur_d + 1);
    end else begin
      req_n   = 0;
      mem_ack = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rand_mode = 0; force_both = 0; start = 0; start2 = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
    ack_q.delete();
    req_n = 0;
    cyc   = 0;
  endtask

  task automatic fill_rom_halt();
    for (int i = 0; i < 256; i++) rom[i] = mk(OP_HALT, 8'h00);
  endtask

  task automatic run_case(input tcase_t tc, input int idx);
    int steps, first, last, reqs, md, valids, done_cyc, span;
    do_reset();
    fill_rom_halt();
    rom[0] = tc.ins;
    ack_q.push_back(tc.ack_wait);
    steps = 0; first = 0; last = 0; reqs = 0; md = 0; valids = 0; done_cyc = 0;
    start = 1;
    tick();
    start = 0;
    for (int n = 0; n < 300; n++) begin
      if (lfsr_step) begin
        if (steps == 0) first = cyc;
        last = cyc;
        steps++;
      end
      if (mem_req) reqs++;
      if (mem_done) md++;
      if (instr_valid) valids++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    span = (steps > 0) ? (last - first + 1) : 0;
    check($sformatf("case%0d_done_cycle", idx), done_cyc, tc.done_cyc);
    check($sformatf("case%0d_steps", idx), steps, tc.steps);
    check($sformatf("case%0d_step_span", idx), span, tc.steps);
    check($sformatf("case%0d_mem_req_cycles", idx), reqs, tc.reqs);
    check($sformatf("case%0d_mem_done", idx), md, tc.mdone);
    check($sformatf("case%0d_valids", idx), valids, tc.valids);
    check($sformatf("case%0d_pc_end", idx), pc, tc.pc_end);
  endtask

  // Instruction-level model: expands each executed instruction into its per-cycle outputs.
  task automatic build_trace();
    obs_t        e;
    int          p, d;
    logic [10:0] prev, ins;
    p = 0;
    prev = '0;
    exp_q.delete();
    for (int guard = 0; guard < 256; guard++) begin
      ins = rom[p];
      e = '0; e.busy = 1; e.pc = 8'(p); e.addr = 8'(p); e.instr = prev;
      e.rom_en = 1; exp_q.push_back(e);
      e.rom_en = 0; exp_q.push_back(e);
      e.instr = ins; e.valid = 1; exp_q.push_back(e);
      e.valid = 0;
      if (ins[10:8] == OP_HALT) begin
        e.busy = 0; e.done = 1; exp_q.push_back(e);
        break;
      end else if (ins[10:8] == OP_ST || ins[10:8] == OP_LD) begin
        d = $urandom_range(0, 4);
        ack_q.push_back(d);
        for (int j = 0; j <= d; j++) begin
          e.req = 1; e.mdone = (j == d); exp_q.push_back(e);
        end
      end else if (ins[10:8] == OP_RUN) begin
        for (int j = 0; j < int'(ins[7:0]); j++) begin
          e.step = 1; exp_q.push_back(e);
        end
      end
      p = (p + 1) % 256;
      prev = ins;
    end
  endtask

  tcase_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{mk(OP_IA, 8'h05),  0,   7,   0, 0, 0, 2, 1};
    tbl[1] = '{mk(OP_CFG, 8'ha5), 0,   7,   0, 0, 0, 2, 1};
    tbl[2] = '{mk(OP_IL, 8'hff),  0,   7,   0, 0, 0, 2, 1};
    tbl[3] = '{mk(OP_ST, 8'h00),  3,  11,   0, 4, 1, 2, 1};
    tbl[4] = '{mk(OP_LD, 8'h10),  0,   8,   0, 1, 1, 2, 1};
    tbl[5] = '{mk(OP_RUN, 8'd5),  0,  12,   5, 0, 0, 2, 1};
    tbl[6] = '{mk(OP_RUN, 8'd0),  0,   7,   0, 0, 0, 2, 1};
    tbl[7] = '{mk(OP_RUN, 8'd1),  0,   8,   1, 0, 0, 2, 1};
    tbl[8] = '{mk(OP_RUN, 8'hff), 0, 262, 255, 0, 0, 2, 1};
    tbl[9] = '{mk(OP_HALT, 8'h00), 0,  4,   0, 0, 0, 1, 0};

    tests = 0; fails = 0; cyc = 0; req_n = 0; cur_d = 0;
    reset = 1; start = 0; start2 = 0; rand_mode = 0; force_both = 0;
    mem_wr_in = 0; lfsr_lmem_in = 0; lfsr_run_in = 0; halt_in = 0; mem_ack = 0;
    rom_data = '0; rom_data2 = '0;
    fill_rom_halt();
    rom2[0] = mk(OP_IA, 8'h01); rom2[1] = mk(OP_AA, 8'h02);
    rom2[2] = mk(OP_CFG, 8'h03); rom2[3] = mk(OP_IL, 8'h04);

    // Reset state
    do_reset();
    check("reset_outs", obs_now(), '0);
    check("reset_outs_pcw2", {rom_en2, instr_valid2, mem_req2, mem_done2, lfsr_step2, busy2, done2, pc2, instr2}, '0);

    // Directed single-instruction table
    for (int i = 0; i < 10; i++) run_case(tbl[i], i);

    // Three-instruction program: valid at 3/6/9, done at 10 with pc=2
    begin
      int vq[$], aq[$], dcyc;
      do_reset();
      fill_rom_halt();
      rom[0] = mk(OP_IA, 8'h05); rom[1] = mk(OP_AA, 8'h03);
      dcyc = 0;
      start = 1; tick(); start = 0;
      for (int n = 0; n < 14; n++) begin
        if (instr_valid) vq.push_back(cyc);
        if (rom_en) aq.push_back(int'(rom_addr));
        if (done && dcyc == 0) dcyc = cyc;
        tick();
      end
      check("prog3_valid_count", vq.size(), 3);
      for (int k = 0; k < 3; k++) check($sformatf("prog3_valid_cycle%0d", k), vq[k], 3 * (k + 1));
      check("prog3_fetch_count", aq.size(), 3);
      for (int k = 0; k < 3; k++) check($sformatf("prog3_rom_addr%0d", k), aq[k], k);
      check("prog3_done_cycle", dcyc, 10);
      check("prog3_pc", pc, 2);
    end

    // Reset in the second RUN cycle of run 10, then restart from 0
    do_reset();
    fill_rom_halt();
    rom[0] = mk(OP_RUN, 8'd10);
    start = 1; tick(); start = 0;
    while (cyc < 5) tick();
    check("run_abort_pre_step", lfsr_step, 1'b1);
    reset = 0; tick(); reset = 1;
    check("run_abort_step", lfsr_step, 1'b0);
    check("run_abort_busy", busy, 1'b0);
    check("run_abort_pc", pc, 0);
    check("run_abort_outs", obs_now(), '0);
    tick(); tick();
    check("run_abort_idle", {rom_en, busy, done}, 3'b000);
    start = 1; tick(); start = 0;
    check("run_abort_refetch", {rom_en, busy, rom_addr}, {1'b1, 1'b1, 8'h00});

    // Reset in the second MEM cycle drops mem_req
    do_reset();
    fill_rom_halt();
    rom[0] = mk(OP_ST, 8'h00);
    ack_q.push_back(50);
    start = 1; tick(); start = 0;
    while (cyc < 5) tick();
    check("mem_abort_pre_req", mem_req, 1'b1);
    reset = 0; tick(); reset = 1;
    check("mem_abort_req", {mem_req, mem_done, busy}, 3'b000);

    // halt_in and mem_wr_in together: halt wins; start in HALT restarts at 0
    begin
      int req_seen;
      do_reset();
      fill_rom_halt();
      rom[0] = mk(OP_IA, 8'h07);
      force_both = 1;
      req_seen = 0;
      start = 1; tick(); start = 0;
      for (int n = 0; n < 10; n++) begin
        if (mem_req) req_seen++;
        tick();
      end
      check("halt_prio_mem_req", req_seen, 0);
      check("halt_prio_done", {done, busy}, 2'b10);
      check("halt_prio_pc", pc, 1);
      force_both = 0;
      start = 1; tick(); start = 0;
      check("halt_restart", {rom_en, rom_addr, pc, busy, done}, {1'b1, 8'h00, 8'h00, 1'b1, 1'b0});
    end

    // PC_W=2 wrap: four plain instructions, no halt
    begin
      int aq[$], k;
      logic bad;
      do_reset();
      bad = 0; k = 0;
      start2 = 1; tick(); start2 = 0;
      for (int n = 0; n < 40; n++) begin
        if (rom_en2) aq.push_back(int'(rom_addr2));
        if (instr_valid2) begin
          check($sformatf("pcw2_instr%0d", k), instr2, rom2[k % 4]);
          check($sformatf("pcw2_pc%0d", k), pc2, k % 4);
          k++;
        end
        if (!busy2 || done2 || mem_req2 || mem_done2 || lfsr_step2) bad = 1;
        tick();
      end
      check("pcw2_stray_outs", bad, 1'b0);
      check("pcw2_fetch_count", aq.size(), 14);
      for (int i = 0; i < 14; i++) check($sformatf("pcw2_rom_addr%0d", i), aq[i], i % 4);
    end

    // Random programs against the trace model, with stray acks and start while busy
    for (int prog = 0; prog < 6; prog++) begin
      int len;
      logic [2:0] op;
      do_reset();
      fill_rom_halt();
      len = $urandom_range(5, 25);
      for (int i = 0; i < len; i++) begin
        op = 3'($urandom_range(0, 6));
        rom[i] = (op == OP_RUN) ? mk(op, 8'($urandom_range(0, 6))) : mk(op, 8'($urandom_range(0, 255)));
      end
      build_trace();
      rand_mode = 1;
      start = 1; tick(); start = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("rand%0d_cyc%0d", prog, i), obs_now(), exp_q[i]);
        start = exp_q[i].busy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (i < exp_q.size() - 1) tick();
      end
      start = 0;
      rand_mode = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
